// File: rtl/password_checker.sv
// password_checker: consumer end of the brute-force candidate stream.
// Candidates are compared against a loaded target in a two-stage pipeline.
// On a hit the generator is stopped and the hit and attempt count are held.
// Optional attempt budget: define ATTEMPT_LIMIT_EN to enable the EXHAUSTED path.
module password_checker #(
  parameter int ATTEMPT_W    = 32,
  parameter int MAX_ATTEMPTS = 1024
) (
  input  logic                 CLK100MHZ,
  input  logic                 CPU_RESETN,
  input  logic                 clear,
  input  logic                 target_load,
  input  logic [127:0]         target_word,
  input  logic [7:0]           target_len,
  input  logic                 start,
  input  logic                 cand_valid,
  input  logic [127:0]         cand_word,
  input  logic [7:0]           cand_len,
  output logic                 cand_ready,
  output logic                 gen_enable,
  output logic                 busy,
  output logic                 found,
  output logic [127:0]         found_word,
  output logic [ATTEMPT_W-1:0] attempts,
  output logic                 exhausted
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_FOUND,
    ST_EXHAUSTED
  } state_t;

`ifdef ATTEMPT_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  localparam logic [ATTEMPT_W-1:0] MAX_CNT = ATTEMPT_W'(MAX_ATTEMPTS);

  state_t r_state;
  state_t w_stateNext;

  logic [127:0]         r_targetWord;
  logic [7:0]           r_targetLen;

  logic                 r_s1Valid;
  logic [127:0]         r_s1Word;
  logic [7:0]           r_s1Len;
  logic [15:0]          w_s1Eq;

  logic                 r_s2Valid;
  logic [127:0]         r_s2Word;
  logic [7:0]           r_s2Len;
  logic [15:0]          r_s2Eq;

  logic [ATTEMPT_W-1:0] r_attempts;
  logic                 r_found;
  logic [127:0]         r_foundWord;

  logic                 w_search;
  logic                 w_xfer;
  logic                 w_lenOk;
  logic                 w_startGo;
  logic                 w_eval;
  logic                 w_match;
  logic                 w_budgetHit;
  logic                 w_stop;
  logic [ATTEMPT_W-1:0] w_attemptsInc;

  // The generator runs and candidates are taken only while searching;
  // these decode the state register directly so they change on the clock edge.
  assign w_search   = (r_state == ST_SEARCH);
  assign busy       = w_search;
  assign gen_enable = w_search;
  assign cand_ready = w_search;

  assign w_xfer     = cand_valid && w_search;
  assign w_lenOk    = (r_targetLen != 8'd0) && (r_targetLen <= 8'd16);
  assign w_startGo  = (r_state == ST_IDLE) && start && w_lenOk;

  // Stage 2 resolves a match from the registered byte-equality vector and length.
  assign w_eval        = w_search && r_s2Valid;
  assign w_match       = w_eval && (&r_s2Eq) && (r_s2Len == r_targetLen);
  assign w_attemptsInc = (&r_attempts) ? r_attempts : (r_attempts + ATTEMPT_W'(1));
  assign w_budgetHit   = LIMIT_EN && w_eval && !w_match && (w_attemptsInc >= MAX_CNT);
  assign w_stop        = w_match || w_budgetHit;

  assign attempts   = r_attempts;
  assign found      = r_found;
  assign found_word = r_foundWord;

  // State register.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic; clear overrides every other input.
  always_comb begin
    w_stateNext = r_state;
    if (clear) begin
      w_stateNext = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_startGo) begin
            w_stateNext = ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          if (w_match) begin
            w_stateNext = ST_FOUND;
          end else if (w_budgetHit) begin
            w_stateNext = ST_EXHAUSTED;
          end
        end
        ST_FOUND:     w_stateNext = ST_FOUND;
        ST_EXHAUSTED: w_stateNext = ST_EXHAUSTED;
        default:      w_stateNext = ST_IDLE;
      endcase
    end
  end

  // Target capture, honoured only in IDLE so a search always sees a stable target.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_targetWord <= '0;
      r_targetLen  <= '0;
    end else if (!clear && (r_state == ST_IDLE) && target_load) begin
      r_targetWord <= target_word;
      r_targetLen  <= target_len;
    end
  end

  // Per-byte equality of the stage-1 candidate against the target; all 16 bytes count.
  always_comb begin
    w_s1Eq = '0;
    for (int i = 0; i < 16; i++) begin
      w_s1Eq[i] = (r_s1Word[8*i +: 8] == r_targetWord[8*i +: 8]);
    end
  end

  // Pipeline valid bits, flushed outside SEARCH and on the edge a search stops.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_s1Valid <= 1'b0;
      r_s2Valid <= 1'b0;
    end else if (clear || !w_search || w_stop) begin
      r_s1Valid <= 1'b0;
      r_s2Valid <= 1'b0;
    end else begin
      r_s1Valid <= w_xfer;
      r_s2Valid <= r_s1Valid;
    end
  end

  // Pipeline data registers; stage 1 holds the accepted candidate, stage 2 its compare result.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_s1Word <= '0;
      r_s1Len  <= '0;
      r_s2Word <= '0;
      r_s2Len  <= '0;
      r_s2Eq   <= '0;
    end else begin
      if (w_xfer) begin
        r_s1Word <= cand_word;
        r_s1Len  <= cand_len;
      end
      r_s2Word <= r_s1Word;
      r_s2Len  <= r_s1Len;
      r_s2Eq   <= w_s1Eq;
    end
  end

  // Attempt counter and sticky hit; zeroed on clear and on starting a new search.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_attempts  <= '0;
      r_found     <= 1'b0;
      r_foundWord <= '0;
    end else if (clear || w_startGo) begin
      r_attempts  <= '0;
      r_found     <= 1'b0;
      r_foundWord <= '0;
    end else if (w_eval) begin
      r_attempts <= w_attemptsInc;
      if (w_match) begin
        r_found     <= 1'b1;
        r_foundWord <= r_s2Word;
      end
    end
  end

`ifdef ATTEMPT_LIMIT_EN
  logic r_exhausted;

  // Sticky budget-spent flag; a match on the final attempt takes precedence.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_exhausted <= 1'b0;
    end else if (clear || w_startGo) begin
      r_exhausted <= 1'b0;
    end else if (w_budgetHit) begin
      r_exhausted <= 1'b1;
    end
  end

  assign exhausted = r_exhausted;
`else
  assign exhausted = 1'b0;
`endif

endmodule

// File: tb/tb_password_checker.sv
// tb_password_checker: directed scenarios plus randomized traffic, all checked
// against a transaction-level model of the checker kept in this bench.
module tb_password_checker;

  localparam int MAX_ATT = 4;
`ifdef ATTEMPT_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  localparam logic [127:0] ABC = 128'h616263;
  localparam logic [127:0] ABD = 128'h616264;
  localparam logic [127:0] ABE = 128'h616265;
  localparam logic [127:0] ABF = 128'h616266;

  localparam int M_IDLE   = 0;
  localparam int M_SEARCH = 1;
  localparam int M_FOUND  = 2;
  localparam int M_EXH    = 3;

  logic         CLK100MHZ = 1'b0;
  logic         CPU_RESETN;
  logic         clear;
  logic         target_load;
  logic [127:0] target_word;
  logic [7:0]   target_len;
  logic         start;
  logic         cand_valid;
  logic [127:0] cand_word;
  logic [7:0]   cand_len;
  logic         cand_ready;
  logic         gen_enable;
  logic         busy;
  logic         found;
  logic [127:0] found_word;
  logic [31:0]  attempts;
  logic         exhausted;

  int errCount   = 0;
  int checkCount = 0;

  password_checker #(
    .ATTEMPT_W   (32),
    .MAX_ATTEMPTS(MAX_ATT)
  ) dut (
    .CLK100MHZ  (CLK100MHZ),
    .CPU_RESETN (CPU_RESETN),
    .clear      (clear),
    .target_load(target_load),
    .target_word(target_word),
    .target_len (target_len),
    .start      (start),
    .cand_valid (cand_valid),
    .cand_word  (cand_word),
    .cand_len   (cand_len),
    .cand_ready (cand_ready),
    .gen_enable (gen_enable),
    .busy       (busy),
    .found      (found),
    .found_word (found_word),
    .attempts   (attempts),
    .exhausted  (exhausted)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: accepted candidates wait in a queue and are judged
  // two edges after acceptance; anything still queued when a search stops is dropped.
  typedef struct {
    logic [127:0] word;
    logic [7:0]   len;
    int           due;
  } cand_t;

  cand_t        pipe[$];
  cand_t        ent;
  int           mMode      = M_IDLE;
  logic [31:0]  mAttempts  = '0;
  logic         mFound     = 1'b0;
  logic [127:0] mFoundWord = '0;
  logic         mExh       = 1'b0;
  logic [127:0] mTWord     = '0;
  logic [7:0]   mTLen      = '0;
  int           cyc        = 0;
  logic         mStop;

  initial begin
    forever begin
      @(posedge CLK100MHZ or negedge CPU_RESETN);
      if (!CPU_RESETN) begin
        mMode = M_IDLE; mAttempts = '0; mFound = 1'b0; mFoundWord = '0;
        mExh = 1'b0; mTWord = '0; mTLen = '0;
        pipe.delete();
      end else begin
        cyc++;
        if (clear) begin
          mMode = M_IDLE; mAttempts = '0; mFound = 1'b0; mFoundWord = '0; mExh = 1'b0;
          pipe.delete();
        end else if (mMode == M_IDLE) begin
          if (start && mTLen >= 8'd1 && mTLen <= 8'd16) begin
            mMode = M_SEARCH; mAttempts = '0; mFoundWord = '0; mFound = 1'b0; mExh = 1'b0;
            pipe.delete();
          end
          if (target_load) begin
            mTWord = target_word;
            mTLen  = target_len;
          end
        end else if (mMode == M_SEARCH) begin
          mStop = 1'b0;
          if (pipe.size() > 0 && pipe[0].due == cyc) begin
            ent = pipe.pop_front();
            if (mAttempts != 32'hFFFF_FFFF) mAttempts = mAttempts + 32'd1;
            if (ent.word == mTWord && ent.len == mTLen) begin
              mFound = 1'b1; mFoundWord = ent.word; mMode = M_FOUND; mStop = 1'b1;
            end else if (LIMIT && mAttempts >= 32'(MAX_ATT)) begin
              mExh = 1'b1; mMode = M_EXH; mStop = 1'b1;
            end
          end
          if (mStop) begin
            pipe.delete();
          end else if (cand_valid) begin
            ent.word = cand_word;
            ent.len  = cand_len;
            ent.due  = cyc + 2;
            pipe.push_back(ent);
          end
        end
      end
    end
  end

  // Every cycle, shortly after the edge, compare all outputs to the model.
  initial begin
    forever begin
      @(posedge CLK100MHZ);
      #1;
      checkOutput("busy",       {127'd0, busy},       {127'd0, mMode == M_SEARCH});
      checkOutput("gen_enable", {127'd0, gen_enable}, {127'd0, mMode == M_SEARCH});
      checkOutput("cand_ready", {127'd0, cand_ready}, {127'd0, mMode == M_SEARCH});
      checkOutput("found",      {127'd0, found},      {127'd0, mFound});
      checkOutput("found_word", found_word,           mFoundWord);
      checkOutput("attempts",   {96'd0, attempts},    {96'd0, mAttempts});
      checkOutput("exhausted",  {127'd0, exhausted},  {127'd0, mExh});
    end
  end

  task automatic applyStimulus(input logic v, input logic [127:0] w, input logic [7:0] l,
                               input logic ld, input logic [127:0] tw, input logic [7:0] tl,
                               input logic st, input logic clr);
    cand_valid  = v;
    cand_word   = w;
    cand_len    = l;
    target_load = ld;
    target_word = tw;
    target_len  = tl;
    start       = st;
    clear       = clr;
    @(negedge CLK100MHZ);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic sendCand(input logic [127:0] w, input logic [7:0] l);
    applyStimulus(1'b1, w, l, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic doLoad(input logic [127:0] tw, input logic [7:0] tl);
    applyStimulus(1'b0, '0, '0, 1'b1, tw, tl, 1'b0, 1'b0);
  endtask

  task automatic doStart();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic doClear();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  function automatic logic [127:0] genWord(input int len, input bit junk);
    logic [127:0] w;
    w = '0;
    for (int i = 0; i < len && i < 16; i++) begin
      w[8*i +: 8] = ($urandom_range(0, 1) == 0) ? 8'h61 : 8'h62;
    end
    if (junk && $urandom_range(0, 9) == 0) w[127:120] = 8'h61;
    return w;
  endfunction

  initial begin
    logic [7:0] tl;
    logic [7:0] cl;
    CPU_RESETN = 1'b0;
    clear = 1'b0; target_load = 1'b0; target_word = '0; target_len = '0;
    start = 1'b0; cand_valid = 1'b0; cand_word = '0; cand_len = '0;
    repeat (2) @(negedge CLK100MHZ);
    checkOutput("reset busy",     {127'd0, busy},  128'd0);
    checkOutput("reset found",    {127'd0, found}, 128'd0);
    checkOutput("reset attempts", {96'd0, attempts}, 128'd0);
    CPU_RESETN = 1'b1;
    idleCycles(1);

    // Mismatch then match back-to-back.
    doLoad(ABC, 8'd3);
    doStart();
    checkOutput("busy after start", {127'd0, busy}, 128'd1);
    sendCand(ABD, 8'd3);
    sendCand(ABC, 8'd3);
    idleCycles(1);
    checkOutput("found one clk early", {127'd0, found}, 128'd0);
    checkOutput("attempts after abd", {96'd0, attempts}, 128'd1);
    idleCycles(1);
    checkOutput("found at latency", {127'd0, found}, 128'd1);
    checkOutput("found_word abc", found_word, ABC);
    checkOutput("attempts after hit", {96'd0, attempts}, 128'd2);
    checkOutput("gen_enable after hit", {127'd0, gen_enable}, 128'd0);

    // Clear returns to IDLE with counters zeroed.
    doClear();
    checkOutput("found after clear", {127'd0, found}, 128'd0);
    checkOutput("attempts after clear", {96'd0, attempts}, 128'd0);

    // Same bytes, wrong length.
    doStart();
    sendCand(ABC, 8'd4);
    idleCycles(2);
    checkOutput("len mismatch attempts", {96'd0, attempts}, 128'd1);
    checkOutput("len mismatch busy", {127'd0, busy}, 128'd1);
    checkOutput("len mismatch found", {127'd0, found}, 128'd0);

    // Candidates behind the match are discarded.
    doClear();
    doStart();
    sendCand(ABC, 8'd3);
    sendCand(ABE, 8'd3);
    sendCand(ABF, 8'd3);
    idleCycles(3);
    checkOutput("discard attempts", {96'd0, attempts}, 128'd1);
    checkOutput("discard found_word", found_word, ABC);

    // Illegal target lengths are ignored by start.
    doClear();
    doLoad(ABC, 8'd0);
    doStart();
    checkOutput("start len0 busy", {127'd0, busy}, 128'd0);
    doLoad(ABC, 8'd17);
    doStart();
    checkOutput("start len17 busy", {127'd0, busy}, 128'd0);

    // Loads during SEARCH are ignored.
    doLoad(ABC, 8'd3);
    doStart();
    doLoad(ABD, 8'd3);
    sendCand(ABC, 8'd3);
    idleCycles(2);
    checkOutput("load ignored in search", {127'd0, found}, 128'd1);

`ifdef ATTEMPT_LIMIT_EN
    doClear();
    doStart();
    for (int i = 0; i < 4; i++) sendCand(ABD, 8'd3);
    idleCycles(2);
    checkOutput("budget exhausted", {127'd0, exhausted}, 128'd1);
    checkOutput("budget gen_enable", {127'd0, gen_enable}, 128'd0);
    checkOutput("budget attempts", {96'd0, attempts}, 128'd4);
    doClear();
    doStart();
    for (int i = 0; i < 3; i++) sendCand(ABD, 8'd3);
    sendCand(ABC, 8'd3);
    idleCycles(2);
    checkOutput("budget last match found", {127'd0, found}, 128'd1);
    checkOutput("budget last match exh", {127'd0, exhausted}, 128'd0);
`endif

    // Randomized traffic over a tiny alphabet so hits are frequent.
    doClear();
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 9) == 0) tl = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'd17;
      else tl = 8'($urandom_range(1, 3));
      cl = 8'($urandom_range(1, 4));
      applyStimulus($urandom_range(0, 3) != 0, genWord(int'(cl), 1'b1), cl,
                    $urandom_range(0, 9) == 0, genWord(int'(tl), 1'b0), tl,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 99) < 3);
    end

    // Asynchronous reset mid-cycle while holding a hit.
    doClear();
    doLoad(ABC, 8'd3);
    doStart();
    sendCand(ABC, 8'd3);
    idleCycles(2);
    @(posedge CLK100MHZ);
    #2;
    CPU_RESETN = 1'b0;
    #1;
    checkOutput("async rst found", {127'd0, found}, 128'd0);
    checkOutput("async rst found_word", found_word, 128'd0);
    checkOutput("async rst attempts", {96'd0, attempts}, 128'd0);
    checkOutput("async rst busy", {127'd0, busy}, 128'd0);
    @(negedge CLK100MHZ);
    CPU_RESETN = 1'b1;
    idleCycles(2);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
